// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink
//   Write-back receiving end of the pipeline. It holds a 32-entry x size-bit
//   architectural register file. It provides two combinational read ports, and
//   a write-back value bypasses to a read port in the same cycle. It also keeps
//   a per-register pending-write scoreboard, which stalls decode until every
//   in-flight producer of a source operand has written back.
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   RD_WB, WE_WB, Final_Result      write-back destination, enable, data
//   RS1_addr/RS2_addr, RSx_used     decode source indices and their use flags
//   issue_valid, issue_rd, issue_we decode issue request and its destination
//   RS1_data, RS2_data              bypassed source operands
//   stall_o, issue_ack              issue refused / issue accepted this cycle
//   wb_err_o                        sticky: write-back to a register with nothing pending
module regfile_wb_sink #(
   parameter int unsigned size     = 32,
   parameter int unsigned max_pend = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      RD_WB,
   input  logic            WE_WB,
   input  logic [size-1:0] Final_Result,
   input  logic [4:0]      RS1_addr,
   input  logic [4:0]      RS2_addr,
   input  logic            RS1_used,
   input  logic            RS2_used,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            issue_we,
   output logic [size-1:0] RS1_data,
   output logic [size-1:0] RS2_data,
   output logic            stall_o,
   output logic            issue_ack,
   output logic            wb_err_o
);

   logic [size-1:0] regs [32];
   logic [1:0]      pend [32];
   logic [1:0]      eff  [32];
   logic            wb_hit;
   logic            wb_err;

   // Write-back is ignored while reset is high, including for the bypass path.
   assign wb_hit = WE_WB & (RD_WB != '0) & ~reset;

   // Effective pending count: a write-back landing this cycle already retires
   // one producer, so same-cycle consumers do not stall on it.
   always_comb begin
      for (int unsigned i = 0; i < 32; i++) begin
         eff[i] = pend[i];
         if (wb_hit && RD_WB == 5'(i) && pend[i] != '0)
            eff[i] = pend[i] - 2'd1;
      end
   end

   always_comb begin
      stall_o = issue_valid &
                ((RS1_used & (eff[RS1_addr] != '0)) |
                 (RS2_used & (eff[RS2_addr] != '0)) |
                 (issue_we & (issue_rd != '0) & (eff[issue_rd] == 2'(max_pend))));
      issue_ack = issue_valid & ~stall_o;
   end

   always_comb begin
      RS1_data = regs[RS1_addr];
      if (RS1_addr == '0)
         RS1_data = '0;
      else if (wb_hit && RD_WB == RS1_addr)
         RS1_data = Final_Result;
      RS2_data = regs[RS2_addr];
      if (RS2_addr == '0)
         RS2_data = '0;
      else if (wb_hit && RD_WB == RS2_addr)
         RS2_data = Final_Result;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs[i] <= '0;
            pend[i] <= '0;
         end
         wb_err <= 1'b0;
      end else begin
         if (wb_hit)
            regs[RD_WB] <= Final_Result;
         for (int unsigned i = 1; i < 32; i++) begin
            logic inc, dec;
            inc = issue_ack & issue_we & (issue_rd == 5'(i));
            dec = wb_hit & (RD_WB == 5'(i));
            if (inc && !dec)
               pend[i] <= pend[i] + 2'd1;
            else if (dec && !inc) begin
               // An unmatched write-back holds the counter at zero and flags the error.
               if (pend[i] == '0)
                  wb_err <= 1'b1;
               else
                  pend[i] <= pend[i] - 2'd1;
            end
         end
      end
   end

   assign wb_err_o = wb_err;

endmodule
